motor_drive_ctrl: RTL and testbench
===================================

MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

Interface
REQ-001 SHALL have parameter NCH, 2, number of independent H-bridge channels (1..8).
REQ-002 SHALL have parameter DAC_W, 4, width of the current-limit DAC word per channel.
REQ-003 SHALL have parameter RAMP_DIV, 1000, clock cycles per ramp step (>=1).
REQ-004 SHALL have parameter DEAD_CYC, 50, brake-hold cycles during a direction reversal (>=1).
REQ-005 SHALL have parameter BRAKE_M, 4, DAC value driven while braking.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port cmd  input  2*NCH  per-channel command: 0 fwd, 1 rev, 2 brake, 3 coast.
REQ-009 SHALL have port mag  input  DAC_W*NCH  per-channel target DAC magnitude for fwd/rev.
REQ-010 SHALL have port m  output  DAC_W*NCH  per-channel DAC drive, registered.
REQ-011 SHALL have port brake  output  NCH  per-channel brake pin, registered.
REQ-012 SHALL have port direction  output  NCH  per-channel direction pin, 1 = forward, registered.
REQ-013 SHALL have port busy  output  NCH  high while the channel is ramping or in dead time.

Function
REQ-014 SHALL evaluate each channel independently; channel i uses cmd[2i+1:2i], mag[DAC_W*i +: DAC_W].
REQ-015 SHALL run one shared prescaler counting 0..RAMP_DIV-1 and assert an internal tick on wrap; the tick is never gated by commands.
REQ-016 SHALL implement per-channel states BRAKE, RUN, DEAD, COAST.
REQ-017 BRAKE: brake=1, m=BRAKE_M, direction held; entered one cycle after cmd=2 from any state, with priority over every other event, including mid-ramp and mid-DEAD.
REQ-018 COAST: brake=0, m=0, direction held; entered one cycle after cmd=3 from any state.
REQ-019 BRAKE/COAST -> RUN on cmd 0/1: next cycle direction = ~cmd[0], brake=0, m=0; ramping starts on following ticks.
REQ-020 RUN, same direction: on each tick m steps by exactly 1 toward mag; no step without a tick; m == mag holds.
REQ-021 RUN, requested direction differs from current: target forced to 0; m steps down by 1 per tick; direction unchanged while m>0.
REQ-022 RUN with m==0 and direction mismatch: next cycle enter DEAD (brake=1, m=0) and load a counter with DEAD_CYC.
REQ-023 DEAD: counter decrements every cycle; on reaching 0, direction = requested, brake=0, state RUN, m=0.
REQ-024 Command reverts to original direction during DEAD: the DEAD count still completes; direction then stays unchanged.
REQ-025 mag change in RUN retargets immediately; ramp proceeds from current m, never jumps.
REQ-026 busy = 1 in DEAD, or in RUN with m != effective target; 0 otherwise.
REQ-027 Arithmetic SHALL be unsigned DAC_W; m SHALL never wrap below 0 or above 2^DAC_W-1.

Reset
REQ-028 While rst_n=0 at a clock edge: all channels BRAKE, direction=1, brake=1, m=BRAKE_M, busy=0, prescaler=0, DEAD counters=0.
REQ-029 Reset asserted mid-ramp or mid-DEAD SHALL abandon the operation with no residual state.
REQ-030 First command SHALL be sampled on the first edge with rst_n=1.

Structure
REQ-031 Shared package motor_drive_pkg SHALL hold the command encoding constants and the channel state enum.
REQ-032 Per-channel logic SHALL be one sub-module motor_ch_fsm, generated NCH times; the prescaler stays in the top level.

Verification (bench: NCH=2, DAC_W=4, RAMP_DIV=4, DEAD_CYC=3, BRAKE_M=4)
REQ-033 Reset -> release, cmd=2 -> m=4, brake=1, direction=1 on both channels, busy=0.
REQ-034 ch0 cmd=0, mag=6 from BRAKE -> next cycle brake=0, m=0; m reaches 6 after 6 ticks (<=24 cycles); busy then 0.
REQ-035 ch0 at m=6 fwd, cmd=1 -> m ramps 6..0 over 6 ticks, then brake=1 for exactly 3 cycles, then direction=0, brake=0, m ramps to mag.
REQ-036 ch0 mid-ramp at m=3, cmd=2 -> next cycle brake=1, m=4; ch1 unaffected in the same cycles.
REQ-037 ch1 in DEAD, rst_n=0 for one edge -> brake=1, m=4, direction=1, busy=0; no reversal completes afterwards.
REQ-038 ch0 RUN at m=5, mag changed to 2 -> m steps 5,4,3,2 one per tick; cmd=3 -> m=0, brake=0, direction held.

Source files
------------

// File: rtl/motor_drive_pkg.sv
// rtl/motor_drive_pkg.sv - command encoding and per-channel state enum
package motor_drive_pkg;

  localparam logic [1:0] CMD_FWD   = 2'd0;
  localparam logic [1:0] CMD_REV   = 2'd1;
  localparam logic [1:0] CMD_BRAKE = 2'd2;
  localparam logic [1:0] CMD_COAST = 2'd3;

  typedef enum logic [1:0] {
    ST_BRAKE = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_COAST = 2'd3
  } ch_state_e;

  // Direction pin value requested by a fwd/rev command (1 = forward).
  function automatic logic cmd_dir(input logic [1:0] c);
    return ~c[0];
  endfunction

endpackage

// File: rtl/motor_drive_ctrl_if.sv
// rtl/motor_drive_ctrl_if.sv - command/drive bundle for one or more H-bridge channels
interface motor_drive_ctrl_if #(
  parameter int NCH   = 2,
  parameter int DAC_W = 4
);

  logic [2*NCH-1:0]     cmd;
  logic [DAC_W*NCH-1:0] mag;
  logic [DAC_W*NCH-1:0] m;
  logic [NCH-1:0]       brake;
  logic [NCH-1:0]       direction;
  logic [NCH-1:0]       busy;

  modport master (output cmd, mag, input m, brake, direction, busy);
  modport slave  (input cmd, mag, output m, brake, direction, busy);

endinterface

// File: rtl/motor_ch_fsm.sv
// rtl/motor_ch_fsm.sv - one H-bridge channel: brake/coast/run ramp and reversal dead time
module motor_ch_fsm
  import motor_drive_pkg::*;
#(
  parameter int DAC_W    = 4,
  parameter int DEAD_CYC = 50,
  parameter int BRAKE_M  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  motor_drive_ctrl_if.slave  ch
);

  localparam int              CNT_W   = $clog2(DEAD_CYC + 1);
  localparam logic [DAC_W-1:0] BRAKE_V = DAC_W'(BRAKE_M);
  localparam logic [DAC_W-1:0] M_ONE   = DAC_W'(1);
  localparam logic [CNT_W-1:0] DEAD_V  = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [DAC_W-1:0] m_q, m_d;
  logic             dir_q, dir_d;
  logic             brake_q, brake_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req_dir;
  logic             mismatch;
  logic [DAC_W-1:0] tgt;

  // A pending reversal forces the ramp target to zero before dead time.
  assign req_dir  = cmd_dir(ch.cmd);
  assign mismatch = !ch.cmd[1] && (req_dir != dir_q);
  assign tgt      = mismatch ? '0 : ch.mag;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (ch.cmd == CMD_BRAKE) begin
      state_d = ST_BRAKE;
      m_d     = BRAKE_V;
      cnt_d   = '0;
    end else if (ch.cmd == CMD_COAST) begin
      state_d = ST_COAST;
      m_d     = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_BRAKE, ST_COAST: begin
          state_d = ST_RUN;
          dir_d   = req_dir;
          m_d     = '0;
        end
        ST_DEAD: begin
          if (cnt_q <= C_ONE) begin
            state_d = ST_RUN;
            dir_d   = req_dir;
            m_d     = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end
        default: begin
          if (mismatch && (m_q == '0)) begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_V;
          end else if (tick && (m_q != tgt)) begin
            m_d = (m_q < tgt) ? (m_q + M_ONE) : (m_q - M_ONE);
          end
        end
      endcase
    end
    brake_d = (state_d == ST_BRAKE) || (state_d == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BRAKE;
      m_q     <= BRAKE_V;
      dir_q   <= 1'b1;
      brake_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      dir_q   <= dir_d;
      brake_q <= brake_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ch.m         = m_q;
  assign ch.brake     = brake_q;
  assign ch.direction = dir_q;
  assign ch.busy      = (state_q == ST_DEAD) || ((state_q == ST_RUN) && (m_q != tgt));

endmodule

// File: rtl/motor_drive_ctrl.sv
// rtl/motor_drive_ctrl.sv - multi-channel H-bridge drive with shared ramp prescaler
module motor_drive_ctrl
  import motor_drive_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DAC_W    = 4,
  parameter int RAMP_DIV = 1000,
  parameter int DEAD_CYC = 50,
  parameter int BRAKE_M  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*NCH-1:0]     cmd,
  input  logic [DAC_W*NCH-1:0] mag,
  output logic [DAC_W*NCH-1:0] m,
  output logic [NCH-1:0]       brake,
  output logic [NCH-1:0]       direction,
  output logic [NCH-1:0]       busy
);

  localparam int               PRE_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RAMP_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre_q;
  logic             tick;

  // Free-running: every channel steps on the same tick regardless of commands.
  assign tick = (pre_q == PRE_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_ONE;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    motor_drive_ctrl_if #(.NCH(1), .DAC_W(DAC_W)) chb ();

    assign chb.cmd                = cmd[2*i +: 2];
    assign chb.mag                = mag[DAC_W*i +: DAC_W];
    assign m[DAC_W*i +: DAC_W]    = chb.m;
    assign brake[i]               = chb.brake[0];
    assign direction[i]           = chb.direction[0];
    assign busy[i]                = chb.busy[0];

    motor_ch_fsm #(
      .DAC_W    (DAC_W),
      .DEAD_CYC (DEAD_CYC),
      .BRAKE_M  (BRAKE_M)
    ) u_fsm (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .ch    (chb.slave)
    );
  end

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb/tb_motor_drive_ctrl.sv - directed and random checks of motor_drive_ctrl against a rule model
module tb_motor_drive_ctrl;

  localparam int NCH      = 2;
  localparam int DAC_W    = 4;
  localparam int RAMP_DIV = 4;
  localparam int DEAD_CYC = 3;
  localparam int BRAKE_M  = 4;

  localparam int MD_BRAKE = 0;
  localparam int MD_RUN   = 1;
  localparam int MD_DEAD  = 2;
  localparam int MD_COAST = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  motor_drive_ctrl_if #(.NCH(NCH), .DAC_W(DAC_W)) bus ();

  motor_drive_ctrl #(
    .NCH(NCH), .DAC_W(DAC_W), .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD_CYC), .BRAKE_M(BRAKE_M)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (bus.cmd),
    .mag       (bus.mag),
    .m         (bus.m),
    .brake     (bus.brake),
    .direction (bus.direction),
    .busy      (bus.busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode, magnitude, direction, dead cycles left, expected busy.
  int md[NCH], mm[NCH], dd[NCH], dc[NCH], mb[NCH];
  int edges_since_rst = 0;
  int cur_c[NCH], cur_g[NCH];

  task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s ch%0d: observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int c, input int g);
    cur_c[ch] = c;
    cur_g[ch] = g;
    bus.cmd[2*ch +: 2]    = 2'(c);
    bus.mag[DAC_W*ch +: DAC_W] = DAC_W'(g);
  endtask

  task automatic check_all();
    for (int ch = 0; ch < NCH; ch++) begin
      chk("m",     ch, 32'(bus.m[DAC_W*ch +: DAC_W]), 32'(mm[ch]));
      chk("brake", ch, 32'(bus.brake[ch]), 32'((md[ch] == MD_BRAKE) || (md[ch] == MD_DEAD)));
      chk("dir",   ch, 32'(bus.direction[ch]), 32'(dd[ch]));
      chk("busy",  ch, 32'(bus.busy[ch]), 32'(mb[ch]));
    end
  endtask

  // One clock edge: apply the behavioural rules, then compare everything.
  task automatic cyc();
    bit tk;
    int want, tgt;
    @(posedge clk);
    if (!rst_n) begin
      edges_since_rst = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        md[ch] = MD_BRAKE; mm[ch] = BRAKE_M; dd[ch] = 1; dc[ch] = 0;
      end
    end else begin
      tk = ((edges_since_rst % RAMP_DIV) == RAMP_DIV - 1);
      edges_since_rst++;
      for (int ch = 0; ch < NCH; ch++) begin
        want = (cur_c[ch] == 0) ? 1 : 0;
        if (cur_c[ch] == 2) begin
          md[ch] = MD_BRAKE; mm[ch] = BRAKE_M;
        end else if (cur_c[ch] == 3) begin
          md[ch] = MD_COAST; mm[ch] = 0;
        end else if (md[ch] == MD_BRAKE || md[ch] == MD_COAST) begin
          md[ch] = MD_RUN; dd[ch] = want; mm[ch] = 0;
        end else if (md[ch] == MD_DEAD) begin
          dc[ch] = dc[ch] - 1;
          if (dc[ch] == 0) begin
            md[ch] = MD_RUN; dd[ch] = want; mm[ch] = 0;
          end
        end else if (want != dd[ch]) begin
          if (mm[ch] == 0) begin
            md[ch] = MD_DEAD; dc[ch] = DEAD_CYC;
          end else if (tk) begin
            mm[ch] = mm[ch] - 1;
          end
        end else if (tk && mm[ch] != cur_g[ch]) begin
          mm[ch] = mm[ch] + ((cur_g[ch] > mm[ch]) ? 1 : -1);
        end
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      want = (cur_c[ch] == 0) ? 1 : 0;
      tgt  = (cur_c[ch] < 2 && want != dd[ch]) ? 0 : cur_g[ch];
      mb[ch] = (md[ch] == MD_DEAD) ? 1 : ((md[ch] == MD_RUN && mm[ch] != tgt) ? 1 : 0);
    end
    #1;
    check_all();
  endtask

  task automatic chk_fixed(input string tag, input int ch, input int em, input int eb, input int ed, input int ebusy);
    chk({tag, "_m"},     ch, 32'(bus.m[DAC_W*ch +: DAC_W]), 32'(em));
    chk({tag, "_brake"}, ch, 32'(bus.brake[ch]), 32'(eb));
    chk({tag, "_dir"},   ch, 32'(bus.direction[ch]), 32'(ed));
    if (ebusy >= 0) chk({tag, "_busy"}, ch, 32'(bus.busy[ch]), 32'(ebusy));
  endtask

  int n, nb, prev;

  initial begin
    rst_n = 1'b0;
    set_ch(0, 2, 0);
    set_ch(1, 2, 0);
    repeat (3) cyc();
    for (int ch = 0; ch < NCH; ch++) chk_fixed("reset", ch, 4, 1, 1, 0);

    rst_n = 1'b1;
    cyc();
    cyc();
    for (int ch = 0; ch < NCH; ch++) chk_fixed("brake_cmd", ch, 4, 1, 1, 0);

    // Forward ramp from brake.
    set_ch(0, 0, 6);
    cyc();
    chk_fixed("run_entry", 0, 0, 0, 1, -1);
    n = 1;
    while (bus.m[3:0] !== 4'd6 && n < 30) begin cyc(); n++; end
    chk("ramp6_within24", 0, 32'(n <= 24), 32'd1);
    chk("ramp6_busy", 0, 32'(bus.busy[0]), 32'd0);

    // Reversal: ramp down, dead time, new direction.
    set_ch(0, 1, 6);
    n = 0;
    while (bus.brake[0] !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("dead_entered", 0, 32'(n < 40), 32'd1);
    chk_fixed("dead_entry", 0, 0, 1, 1, 1);
    nb = 0;
    while (bus.brake[0] === 1'b1 && nb < 10) begin nb++; cyc(); end
    chk("dead_len", 0, 32'(nb), 32'(DEAD_CYC));
    chk_fixed("dead_exit", 0, 0, 0, 0, -1);
    n = 0;
    while (bus.m[3:0] !== 4'd6 && n < 30) begin cyc(); n++; end
    chk("rev_ramp6", 0, 32'(n < 30), 32'd1);

    // Brake mid-ramp on ch0 while ch1 ramps independently.
    set_ch(1, 0, 9);
    set_ch(0, 2, 6);
    cyc();
    set_ch(0, 0, 6);
    n = 0;
    while (bus.m[3:0] !== 4'd3 && n < 20) begin cyc(); n++; end
    chk("midramp_m3", 0, 32'(n < 20), 32'd1);
    set_ch(0, 2, 6);
    cyc();
    chk_fixed("midramp_brake", 0, 4, 1, 1, 0);

    // Reset during ch1 dead time.
    set_ch(1, 1, 9);
    n = 0;
    while (bus.brake[1] !== 1'b1 && n < 80) begin cyc(); n++; end
    chk("ch1_dead_entered", 1, 32'(n < 80), 32'd1);
    rst_n = 1'b0;
    cyc();
    chk_fixed("rst_in_dead", 1, 4, 1, 1, 0);
    rst_n = 1'b1;
    set_ch(0, 2, 0);
    set_ch(1, 2, 0);
    repeat (8) cyc();
    chk_fixed("no_residual", 1, 4, 1, 1, 0);

    // Retarget downward mid-run, then coast.
    set_ch(0, 0, 5);
    n = 0;
    while (bus.m[3:0] !== 4'd5 && n < 40) begin cyc(); n++; end
    chk("ramp5", 0, 32'(n < 40), 32'd1);
    set_ch(0, 0, 2);
    prev = 5;
    for (int v = 4; v >= 2; v--) begin
      n = 0;
      while (32'(bus.m[3:0]) == prev && n < 8) begin cyc(); n++; end
      chk("retarget_step", 0, 32'(bus.m[3:0]), 32'(v));
      prev = v;
    end
    set_ch(0, 3, 2);
    cyc();
    chk_fixed("coast", 0, 0, 0, 1, 0);

    // Random commands, magnitudes and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int ch = 0; ch < NCH; ch++) begin
        int c, g;
        c = cur_c[ch];
        g = cur_g[ch];
        if ($urandom_range(0, 15) == 0) begin
          c = $urandom_range(0, 5);
          if (c > 3) c = c - 4;
        end
        if ($urandom_range(0, 9) == 0) g = $urandom_range(0, 15);
        set_ch(ch, c, g);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
